// File: rtl/sccb_cmd_arbiter.sv
// Purpose: shares one SCCB/I2C driver between the power-up sequencer (ch0) and runtime control (ch1).
// Latency: ack 1 cycle after grant, i2c_exec 1 cycle after ack, done when the driver finishes or on timeout.
// Backpressure: requesters hold req until ack; no new grant until WAIT and the inter-command GAP finish.
module sccb_cmd_arbiter #(
  parameter int ARB_MODE       = 0,
  parameter int GAP_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rh_wl0,
  input  logic        rh_wl1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        timeout_flag,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done
);

  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW_RAW = $clog2(GAP_CYCLES + 1);
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;     // channel that owns the current transaction
  logic          rr_ptr_q, rr_ptr_d;   // channel favoured when both request (round-robin)
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          tflag_q, tflag_d;
  logic          exec_q, exec_d;
  logic          rh_wl_q, rh_wl_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dataw_q, dataw_d;
  logic          pick1;
  logic          finish;
  logic          finish_err;

  // Winner selection: fixed priority to ch0, or alternate when both request.
  always_comb begin
    pick1 = 1'b0;
    if (ARB_MODE == 0) begin
      pick1 = ~req0;
    end else if (req0 && req1) begin
      pick1 = rr_ptr_q;
    end else begin
      pick1 = ~req0;
    end
  end

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/GAP sequence.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    exec_d     = 1'b0;
    rdata_d    = rdata_q;
    tflag_d    = tflag_q;
    rh_wl_d    = rh_wl_q;
    addr_d     = addr_q;
    dataw_d    = dataw_q;
    finish     = 1'b0;
    finish_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d  = pick1;
          rr_ptr_d = ~pick1;
          rh_wl_d  = pick1 ? rh_wl1 : rh_wl0;
          addr_d   = pick1 ? addr1  : addr0;
          dataw_d  = pick1 ? wdata1 : wdata0;
          ack0_d   = ~pick1;
          ack1_d   = pick1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        exec_d  = 1'b1;
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the threshold cycle beats the timeout.
        if (i2c_done) begin
          finish = 1'b1;
          if (rh_wl_q) begin
            rdata_d = i2c_data_r;
          end
        end else if (tcnt_q == TO_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          tflag_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (finish) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          err0_d  = ~owner_q & finish_err;
          err1_d  = owner_q & finish_err;
          gcnt_d  = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata_q  <= '0;
      tflag_q  <= 1'b0;
      exec_q   <= 1'b0;
      rh_wl_q  <= 1'b0;
      addr_q   <= '0;
      dataw_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata_q  <= rdata_d;
      tflag_q  <= tflag_d;
      exec_q   <= exec_d;
      rh_wl_q  <= rh_wl_d;
      addr_q   <= addr_d;
      dataw_q  <= dataw_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_flag = tflag_q;
  assign i2c_exec     = exec_q;
  assign i2c_rh_wl    = rh_wl_q;
  assign i2c_addr     = addr_q;
  assign i2c_data_w   = dataw_q;

endmodule
